// File: rtl/gearbox_pkg.sv
// Shared helpers for the data_gearbox width converter family.
// Per-instance widths stay local to each module; only width math lives here.
package gearbox_pkg;

    localparam int MAX_W = 64;

    // Counter width able to hold every value 0..buf_w inclusive.
    function automatic int clog2_fill(input int buf_w);
        return $clog2(buf_w + 1);
    endfunction

    localparam int MAX_CNT_W = clog2_fill(2 * (MAX_W + MAX_W));

    // Fill count wide enough for the largest legal accumulator.
    typedef logic [MAX_CNT_W-1:0] fill_max_t;

endpackage

// File: rtl/data_gearbox.sv
// Packs IN_W-bit words into OUT_W-bit words LSB-first through a shift accumulator,
// with valid/ready on both sides and a zero-padded, last-tagged flush at packet end.
module data_gearbox
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 23,
    localparam int BUF_W = 2 * (IN_W + OUT_W),
    localparam int CNT_W = clog2_fill(BUF_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_src,
    input  logic [IN_W-1:0]  data_in,
    input  logic             last_src,
    output logic             rdy_src,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_sink,
    output logic             last_sink,
    input  logic             rdy_sink,
    output logic [CNT_W-1:0] fill
);

    localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(BUF_W - IN_W);
    localparam logic [CNT_W-1:0] BUF_W_C = CNT_W'(BUF_W);

    logic [BUF_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] fill_reg, fill_next, pop_cnt;
    logic             draining_reg, draining_next;
    logic             push, pop;

    // Every handshake output derives from registered state only.
    assign rdy_src    = !draining_reg && (fill_reg <= RDY_MAX);
    assign valid_sink = (fill_reg >= OUT_W_C) || (draining_reg && (fill_reg != '0));
    assign last_sink  = draining_reg && (fill_reg <= OUT_W_C);
    assign data_out   = acc_reg[OUT_W-1:0];
    assign fill       = fill_reg;

    assign push = valid_src && rdy_src;
    assign pop  = valid_sink && rdy_sink;

    always_comb begin
        pop_cnt       = '0;
        draining_next = draining_reg;
        if (pop) begin
            pop_cnt = (fill_reg < OUT_W_C) ? fill_reg : OUT_W_C;
        end
        acc_next  = acc_reg >> pop_cnt;
        fill_next = fill_reg - pop_cnt;
        if (push) begin
            // New word lands directly above whatever survives this cycle's pop.
            acc_next  = acc_next | (BUF_W'(data_in) << fill_next);
            fill_next = fill_next + IN_W_C;
            if (last_src) begin
                draining_next = 1'b1;
            end
        end
        // The padded final beat swallows the remainder; push cannot coincide (draining blocks it).
        if (pop && last_sink) begin
            acc_next      = '0;
            fill_next     = '0;
            draining_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg      <= '0;
            fill_reg     <= '0;
            draining_reg <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            fill_reg     <= fill_next;
            draining_reg <= draining_next;
        end
    end

`ifndef SYNTHESIS
    a_fill_max: assert property (@(posedge clk) disable iff (!rst)
        fill_reg <= BUF_W_C);

    a_zero_above_fill: assert property (@(posedge clk) disable iff (!rst)
        (acc_reg >> fill_reg) == '0);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (valid_sink && !rdy_sink) |=> ($stable(data_out) && $stable(last_sink)));
`endif

endmodule

// File: tb/tb_data_gearbox.sv
// Directed vectors and multi-cycle sequences on a 16->23 gearbox, plus randomised
// packet streams on several width pairs checked against a bit-serial reference.
module tb_data_gearbox;

    logic        clk;
    logic        rst;
    logic        rst_sw;
    logic        valid_src;
    logic [15:0] data_in;
    logic        last_src;
    logic        rdy_src;
    logic [22:0] data_out;
    logic        valid_sink;
    logic        last_sink;
    logic        rdy_sink;
    logic [6:0]  fill;

    int n_checks;
    int n_fail;
    int sweep_done;

    localparam int SW_PKTS   = 1000;
    localparam int SW_BUDGET = 40000;

    data_gearbox #(.IN_W(16), .OUT_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_src  (valid_src),
        .data_in    (data_in),
        .last_src   (last_src),
        .rdy_src    (rdy_src),
        .data_out   (data_out),
        .valid_sink (valid_sink),
        .last_sink  (last_sink),
        .rdy_sink   (rdy_sink),
        .fill       (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic rs);
        @(posedge clk);
        #1;
        valid_src = v;
        data_in   = d;
        last_src  = l;
        rdy_sink  = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_src = 1'b0;
        last_src  = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [15:0] pkt_word(input int mode, input int i);
        logic [15:0] w;
        w = (mode == 0) ? 16'hA5A5 : 16'h1000 + 16'(i * 16'h1357);
        return w;
    endfunction

    // Streams one packet, checking every beat against a bit-level reference.
    // rdy_sink is held low for the first 'hold' cycles.
    task automatic send_packet(input string tag, input int nw, input int mode,
                               input int hold, input int hold_sent);
        bit          q[$];
        int          sent, beats, total, cyc, pad;
        logic [22:0] exp_w;
        sent  = 0;
        beats = 0;
        cyc   = 0;
        total = (nw * 16 + 22) / 23;
        while (beats < total && cyc < 400) begin
            @(posedge clk);
            #1;
            valid_src = (sent < nw);
            data_in   = pkt_word(mode, sent);
            last_src  = (sent == nw - 1);
            rdy_sink  = (cyc >= hold);
            @(negedge clk);
            if (hold > 1 && cyc == hold - 1) begin
                chk({tag, "_hold_sent"}, 64'(sent), 64'(hold_sent));
                chk({tag, "_hold_rdy_src"}, 64'(rdy_src), 64'(0));
                chk({tag, "_hold_fill"}, 64'(fill), 64'(hold_sent * 16));
            end
            if (valid_sink && !rdy_sink && q.size() >= 23) begin
                for (int j = 0; j < 23; j++) exp_w[j] = q[j];
                chk({tag, "_held_data"}, 64'(data_out), 64'(exp_w));
            end
            if (valid_sink && rdy_sink) begin
                if (q.size() < 23) begin
                    chk({tag, "_spurious_beat"}, 64'(q.size()), 64'(23));
                end else begin
                    for (int j = 0; j < 23; j++) exp_w[j] = q.pop_front();
                    chk($sformatf("%s_beat%0d_data", tag, beats), 64'(data_out), 64'(exp_w));
                    chk($sformatf("%s_beat%0d_last", tag, beats), 64'(last_sink),
                        64'(beats == total - 1));
                end
                $display("%s beat %0d: data_out=%h last_sink=%0b", tag, beats, data_out, last_sink);
                beats++;
            end
            if (valid_src && rdy_src) begin
                for (int j = 0; j < 16; j++) q.push_back(data_in[j]);
                sent++;
                if (last_src) begin
                    pad = (23 - (sent * 16) % 23) % 23;
                    repeat (pad) q.push_back(1'b0);
                end
            end
            cyc++;
        end
        chk({tag, "_beat_count"}, 64'(beats), 64'(total));
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk({tag, "_end_fill"}, 64'(fill), 64'(0));
        chk({tag, "_end_valid_sink"}, 64'(valid_sink), 64'(0));
        chk({tag, "_end_rdy_src"}, 64'(rdy_src), 64'(1));
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        rs;
        logic        e_valid;
        logic [22:0] e_data;
        logic        e_last;
        logic [6:0]  e_fill;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        sweep_done = 0;
        rst        = 1'b0;
        rst_sw     = 1'b0;
        valid_src  = 1'b0;
        data_in    = '0;
        last_src   = 1'b0;
        rdy_sink   = 1'b0;

        // Outputs appear in the cycle they are listed; inputs take effect at the following edge.
        vecs[0]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 23'h000000, 1'b0, 7'd0,  1'b1};
        vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 23'h00FFFF, 1'b0, 7'd16, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 23'h00FFFF, 1'b0, 7'd32, 1'b1};
        vecs[3]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 23'h000000, 1'b0, 7'd9,  1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 23'h246800, 1'b0, 7'd25, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 23'h000000, 1'b1, 7'd2,  1'b0};
        vecs[6]  = '{1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, 23'h000000, 1'b0, 7'd0,  1'b1};
        vecs[7]  = '{1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 23'h00ABCD, 1'b0, 7'd16, 1'b1};
        vecs[8]  = '{1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1, 23'h55ABCD, 1'b0, 7'd32, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 23'h01FEAA, 1'b0, 7'd25, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 23'h01FEAA, 1'b0, 7'd25, 1'b1};
        vecs[11] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 23'h000000, 1'b0, 7'd2,  1'b1};
        vecs[12] = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b1, 23'h020004, 1'b1, 7'd18, 1'b0};
        vecs[13] = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 23'h000000, 1'b0, 7'd0,  1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 23'h007777, 1'b0, 7'd16, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_sink", 64'(valid_sink), 64'(0));
        chk("reset_last_sink", 64'(last_sink), 64'(0));
        chk("reset_data_out", 64'(data_out), 64'(0));
        chk("reset_fill", 64'(fill), 64'(0));
        chk("reset_rdy_src", 64'(rdy_src), 64'(1));
        @(posedge clk);
        #1;
        rst    = 1'b1;
        rst_sw = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].rs);
            chk($sformatf("vec%0d_valid_sink", i), 64'(valid_sink), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data_out", i), 64'(data_out), 64'(vecs[i].e_data));
            chk($sformatf("vec%0d_last_sink", i), 64'(last_sink), 64'(vecs[i].e_last));
            chk($sformatf("vec%0d_fill", i), 64'(fill), 64'(vecs[i].e_fill));
            chk($sformatf("vec%0d_rdy_src", i), 64'(rdy_src), 64'(vecs[i].e_rdy));
            $display("vec %0d: v=%0b d=%h l=%0b rs=%0b -> valid_sink=%0b data_out=%h last_sink=%0b fill=%0d rdy_src=%0b",
                     i, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].rs,
                     valid_sink, data_out, last_sink, fill, rdy_src);
        end

        do_reset();
        send_packet("exact_fit", 23, 0, 0, 0);
        do_reset();
        send_packet("backpressure", 8, 1, 10, 4);

        // Reset in the middle of a draining packet.
        do_reset();
        step(1'b1, 16'hFFFF, 1'b0, 1'b1);
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("midrst_pre_fill", 64'(fill), 64'(25));
        chk("midrst_pre_rdy_src", 64'(rdy_src), 64'(0));
        rst = 1'b0;
        #1;
        chk("midrst_valid_sink", 64'(valid_sink), 64'(0));
        chk("midrst_fill", 64'(fill), 64'(0));
        chk("midrst_rdy_src", 64'(rdy_src), 64'(1));
        chk("midrst_last_sink", 64'(last_sink), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst_after_edge_valid", 64'(valid_sink), 64'(0));
        rst = 1'b1;
        step(1'b1, 16'h0F0F, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("midrst_new_data", 64'(data_out), 64'(23'h000F0F));
        chk("midrst_new_fill", 64'(fill), 64'(16));
        $display("reset mid-packet: new word data_out=%h fill=%0d", data_out, fill);

        wait (sweep_done == 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic int sw_in(input int i);
        case (i)
            0:       return 8;
            1:       return 32;
            2:       return 23;
            default: return 1;
        endcase
    endfunction

    function automatic int sw_out(input int i);
        case (i)
            0:       return 32;
            1:       return 8;
            2:       return 16;
            default: return 7;
        endcase
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
        localparam int IW = sw_in(gi);
        localparam int OW = sw_out(gi);
        localparam int CW = $clog2(2 * (IW + OW) + 1);

        logic          v, l, rs, rdy, vs, ls;
        logic [IW-1:0] d;
        logic [OW-1:0] q;
        logic [CW-1:0] f;

        data_gearbox #(.IN_W(IW), .OUT_W(OW)) u_dut (
            .clk        (clk),
            .rst        (rst_sw),
            .valid_src  (v),
            .data_in    (d),
            .last_src   (l),
            .rdy_src    (rdy),
            .data_out   (q),
            .valid_sink (vs),
            .last_sink  (ls),
            .rdy_sink   (rs),
            .fill       (f)
        );

        initial begin : sw_proc
            bit            exp_q[$];
            int            last_q[$];
            int            pkts, words_left, pkt_bits, beat_idx, beat_total, cyc, pad;
            logic          pending;
            logic [OW-1:0] exp_w;
            logic          exp_l;
            pkts       = 0;
            pkt_bits   = 0;
            beat_idx   = 0;
            beat_total = 0;
            cyc        = 0;
            pending    = 1'b0;
            v          = 1'b0;
            l          = 1'b0;
            rs         = 1'b0;
            d          = '0;
            wait (rst_sw === 1'b1);
            words_left = $urandom_range(1, 4);
            while (cyc < SW_BUDGET && !(pkts == SW_PKTS && exp_q.size() == 0)) begin
                @(posedge clk);
                #1;
                if (!pending) begin
                    if (pkts < SW_PKTS && $urandom_range(0, 3) != 0) begin
                        v = 1'b1;
                        d = IW'($urandom);
                        l = (words_left == 1);
                    end else begin
                        v = 1'b0;
                        l = 1'b0;
                    end
                end
                rs = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (vs && rs) begin
                    if (exp_q.size() < OW) begin
                        chk($sformatf("sw%0d_spurious_beat%0d", gi, beat_idx), 64'(exp_q.size()), 64'(OW));
                    end else begin
                        for (int j = 0; j < OW; j++) exp_w[j] = exp_q.pop_front();
                        exp_l = (last_q.size() != 0) && (last_q[0] == beat_idx);
                        if (exp_l) void'(last_q.pop_front());
                        chk($sformatf("sw%0d_beat%0d_data", gi, beat_idx), 64'(q), 64'(exp_w));
                        chk($sformatf("sw%0d_beat%0d_last", gi, beat_idx), 64'(ls), 64'(exp_l));
                    end
                    beat_idx++;
                end
                if (v && rdy) begin
                    for (int j = 0; j < IW; j++) exp_q.push_back(d[j]);
                    pkt_bits += IW;
                    words_left--;
                    if (l) begin
                        pad = (OW - pkt_bits % OW) % OW;
                        repeat (pad) exp_q.push_back(1'b0);
                        beat_total += (pkt_bits + pad) / OW;
                        last_q.push_back(beat_total - 1);
                        pkt_bits   = 0;
                        pkts++;
                        words_left = $urandom_range(1, 4);
                    end
                    pending = 1'b0;
                end else begin
                    pending = v;
                end
                cyc++;
            end
            chk($sformatf("sw%0d_finished_in_budget", gi), 64'(cyc < SW_BUDGET), 64'(1));
            @(posedge clk);
            #1;
            v  = 1'b0;
            rs = 1'b1;
            @(negedge clk);
            chk($sformatf("sw%0d_end_fill", gi), 64'(f), 64'(0));
            chk($sformatf("sw%0d_end_valid_sink", gi), 64'(vs), 64'(0));
            $display("sweep %0d (IN_W=%0d OUT_W=%0d): %0d packets, %0d beats", gi, IW, OW, pkts, beat_idx);
            sweep_done++;
        end
    end

endmodule
